// File: rtl/imem_loader_pkg.sv
// Shared types, constants and helpers for the UART boot-image loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_LEN_LO    = 3'd1,
        ST_LEN_HI    = 3'd2,
        ST_DATA      = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK     = 3'd4,
`endif
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } loader_state_e;

    // Clock cycles per UART bit; the receiver needs at least 4.
    function automatic int calc_div(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit qualification at mid-bit,
// LSB-first shifter and stop-bit check. Emits one-cycle valid or framing-error strobes.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output rx_state_e  state_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [2:0]       sync_q;
    logic             rx_s;
    logic             fall;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shreg_q;
    logic             half_hit;
    logic             full_hit;

    // sync_q[1] is the first metastability-safe sample; sync_q[2] is its previous value.
    assign rx_s     = sync_q[1];
    assign fall     = sync_q[2] & ~sync_q[1];
    assign half_hit = (cnt_q == HALF_LAST);
    assign full_hit = (cnt_q == FULL_LAST);
    assign state_o  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (full_hit) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            // The counter restarts at every sample point so later samples sit mid-bit.
            if (state_q == RX_IDLE || (state_q == RX_START && half_hit) || full_hit) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RX_START && half_hit) begin
                bit_q <= '0;
            end
            if (state_q == RX_DATA && full_hit) begin
                shreg_q <= {rx_s, shreg_q[7:1]};
                bit_q   <= bit_q + 1'b1;
            end
            if (state_q == RX_STOP && full_hit) begin
                if (rx_s) begin
                    valid_o <= 1'b1;
                    byte_o  <= shreg_q;
                end else begin
                    frame_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed image over UART, writes it into instruction memory and
// holds the core in reset until complete. IMEM_LOADER_CHECKSUM_EN enables the trailing CHK byte.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter  int CLK_FREQ_HZ = 100_000_000,
    parameter  int BAUD        = 115200,
    parameter  int IMEM_WORDS  = 256,
    localparam int ADDR_W      = $clog2(IMEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_error,
    output loader_state_e     dbg_state,
    output rx_state_e         dbg_rx_state
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e POST_DATA = ST_CHECK;
`else
    localparam loader_state_e POST_DATA = ST_DONE;
`endif

    loader_state_e state_q;
    loader_state_e state_d;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    logic [7:0]    len_lo_q;
    logic [15:0]   len_q;
    logic [15:0]   len_in;
    logic [15:0]   addr_ext;
    logic [1:0]    byte_idx_q;
    logic          sync_hit;
    logic          len_over;
    logic          last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    // rx_valid / rx_ferr are single-cycle strobes with no back-pressure: a byte is either
    // consumed in the cycle it is presented or lost; there is no ready signal.
    uart_rx_byte #(
        .DIV(DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .frame_err_o(rx_ferr),
        .state_o    (dbg_rx_state)
    );

    assign len_in    = {rx_byte, len_lo_q};
    assign len_over  = (32'(len_in) > 32'(IMEM_WORDS));
    assign sync_hit  = rx_valid && (rx_byte == SYNC_BYTE);
    assign addr_ext  = 16'(imem_addr);
    assign last_word = ((addr_ext + 16'd1) == len_q);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = ST_WAIT_SYNC;
        end else begin
            case (state_q)
                ST_WAIT_SYNC: if (sync_hit) state_d = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (rx_ferr) state_d = ST_ERROR;
                    else if (rx_valid) state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (rx_ferr) state_d = ST_ERROR;
                    else if (rx_valid) begin
                        if (len_over) state_d = ST_ERROR;
                        else if (len_in == 16'd0) state_d = POST_DATA;
                        else state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) state_d = ST_ERROR;
                    else if (rx_valid && byte_idx_q == 2'd3 && last_word) state_d = POST_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_ferr) state_d = ST_ERROR;
                    else if (rx_valid) state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERROR;
                end
`endif
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_WAIT_SYNC;
                default:  state_d = ST_WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
        end else begin
            imem_we <= 1'b0;
            if (reload) begin
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                busy       <= 1'b0;
                imem_addr  <= '0;
                byte_idx_q <= '0;
            end else begin
                // Advance the word index only after its write strobe, and never past the last word.
                if (imem_we && !last_word) begin
                    imem_addr <= imem_addr + 1'b1;
                end
                case (state_q)
                    ST_WAIT_SYNC: begin
                        if (sync_hit) begin
                            busy       <= 1'b1;
                            load_error <= 1'b0;
                            imem_addr  <= '0;
                            byte_idx_q <= '0;
                        end
                    end
                    ST_LEN_LO: if (rx_valid) len_lo_q <= rx_byte;
                    ST_LEN_HI: if (rx_valid) len_q <= len_in;
                    ST_DATA: begin
                        if (rx_valid) begin
                            imem_wdata[{byte_idx_q, 3'b000} +: 8] <= rx_byte;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            if (byte_idx_q == 2'd3) imem_we <= 1'b1;
                        end
                    end
                    ST_DONE: core_reset <= 1'b0;
                    default: ;
                endcase
                if (state_d == ST_DONE && state_q != ST_DONE) begin
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                end
                if (state_d == ST_ERROR) begin
                    busy       <= 1'b0;
                    load_error <= 1'b1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over LEN_LO, LEN_HI and every data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else if (reload || (state_q == ST_WAIT_SYNC && sync_hit)) begin
            chk_q <= '0;
        end else if (rx_valid && (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
                                  state_q == ST_DATA)) begin
            chk_q <= chk_q ^ rx_byte;
        end
    end
`endif

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table-driven frames, hand-written corner sequences and
// random frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_imem_uart_loader;
    import imem_loader_pkg::*;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD        = 100_000;
    localparam int IMEM_WORDS  = 16;
    localparam int DIV         = CLK_FREQ_HZ / BAUD;
    localparam int ADDR_W      = 4;
    localparam int W           = ADDR_W + 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int NV = 5;
`else
    localparam int NV = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              uart_rx;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              load_done;
    logic              load_error;
    loader_state_e     dbg_state;
    rx_state_e         dbg_rx_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    logic [7:0]   frm[$];
    bit           m_done;
    bit           m_err;

    typedef struct {
        logic [95:0] bytes;   // first byte in the most significant used position
        int          nb;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;
    vec_t vecs[NV];

    imem_uart_loader #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .reload      (reload),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_reset  (core_reset),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error),
        .dbg_state   (dbg_state),
        .dbg_rx_state(dbg_rx_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%h expected none", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL imem_write got addr=%0h data=%h expected addr=%0h data=%h",
                             imem_addr, imem_wdata, exp_w[W-1:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = good_stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!good_stop) repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_frame();
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic load_test1();
        logic [7:0] t1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00};
        frm.delete();
        for (int i = 0; i < 11; i++) frm.push_back(t1[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frm.push_back(8'h92);
`endif
    endtask

    // Frame-level model: skip to the sync byte, read the length, slice words, check XOR.
    function automatic void run_model();
        int         i;
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        m_done = 1'b0;
        m_err  = 1'b0;
        i = 0;
        while (i < frm.size() && frm[i] != SYNC_BYTE) i++;
        if (i >= frm.size()) return;
        i++;
        if (i + 2 > frm.size()) return;
        n = int'({frm[i+1], frm[i]});
        x = frm[i] ^ frm[i+1];
        i += 2;
        if (n > IMEM_WORDS) begin
            m_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > frm.size()) return;
            w = {frm[i+3], frm[i+2], frm[i+1], frm[i]};
            x = x ^ frm[i] ^ frm[i+1] ^ frm[i+2] ^ frm[i+3];
            exp_q.push_back({ADDR_W'(k), w});
            i += 4;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (i >= frm.size()) return;
        if (frm[i] == x) m_done = 1'b1;
        else m_err = 1'b1;
`else
        m_done = 1'b1;
`endif
    endfunction

    task automatic finish_frame(input string tag, input bit e_done, input bit e_err);
        repeat (2 * DIV) @(negedge clk);
        check({tag, "_load_done"}, load_done, e_done);
        check({tag, "_load_error"}, load_error, e_err);
        check({tag, "_core_reset"}, core_reset, !e_done);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_state"}, dbg_state, e_done ? ST_DONE : ST_WAIT_SYNC);
        check({tag, "_rx_idle"}, dbg_rx_state, RX_IDLE);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_we"}, imem_we, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_core_reset"}, core_reset, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_load_done"}, load_done, 1'b0);
        check({tag, "_load_error"}, load_error, 1'b0);
    endtask

    initial begin
        logic [95:0] vb;
        reset   = 1'b1;
        uart_rx = 1'b1;
        reload  = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[0] = '{96'hA5_02_00_13_00_00_00_93_00_10_00_92, 12, 1'b1, 1'b0, 2};
        vecs[1] = '{96'h00_FF_A5_00_00_00, 6, 1'b1, 1'b0, 0};
        vecs[2] = '{96'hA5_11_00, 3, 1'b0, 1'b1, 0};
        vecs[3] = '{96'hA5_01_00_EF_BE_AD_DE_23, 8, 1'b1, 1'b0, 1};
        vecs[4] = '{96'hA5_02_00_13_00_00_00_93_00_10_00_81, 12, 1'b0, 1'b1, 2};
`else
        vecs[0] = '{96'hA5_02_00_13_00_00_00_93_00_10_00, 11, 1'b1, 1'b0, 2};
        vecs[1] = '{96'h00_FF_A5_00_00, 5, 1'b1, 1'b0, 0};
        vecs[2] = '{96'hA5_11_00, 3, 1'b0, 1'b1, 0};
        vecs[3] = '{96'hA5_01_00_EF_BE_AD_DE, 7, 1'b1, 1'b0, 1};
`endif

        // Clock / reset
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("after_reset");

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            frm.delete();
            vb = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nb; i++) frm.push_back(vb[8*(vecs[v].nb-1-i) +: 8]);
            run_model();
            do_reload();
            wr_cnt = 0;
            send_frame();
            finish_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
            check($sformatf("vec%0d_writes", v), wr_cnt, vecs[v].exp_writes);
        end

        // Framing error while waiting for sync is ignored
        do_reload();
        send_byte(8'h3C, 1'b0);
        check("wait_sync_ferr_error", load_error, 1'b0);
        check("wait_sync_ferr_busy", busy, 1'b0);

        // Framing error mid-data, then a clean resend
        wr_cnt = 0;
        send_byte(8'hA5, 1'b1);
        check("busy_after_sync", busy, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        check("ferr_load_error", load_error, 1'b1);
        check("ferr_core_reset", core_reset, 1'b1);
        check("ferr_busy", busy, 1'b0);
        check("ferr_writes", wr_cnt, 0);
        load_test1();
        run_model();
        send_frame();
        finish_frame("resend", 1'b1, 1'b0);

        // Reload after DONE takes effect on the next cycle
        check("pre_reload_core_reset", core_reset, 1'b0);
        do_reload();
        check("reload_core_reset", core_reset, 1'b1);
        check("reload_load_done", load_done, 1'b0);
        check("reload_imem_addr", imem_addr, 0);

        // Random frames: full-depth image, oversize length and short images
        for (int f = 0; f < 6; f++) begin
            int         n;
            int         nj;
            logic [7:0] b;
            logic [7:0] x;
            frm.delete();
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC_BYTE) b = 8'h5A;
                frm.push_back(b);
            end
            n = (f == 0) ? IMEM_WORDS : (f == 1) ? $urandom_range(17, 300) : $urandom_range(0, 5);
            frm.push_back(SYNC_BYTE);
            frm.push_back(n[7:0]);
            frm.push_back(n[15:8]);
            x = n[7:0] ^ n[15:8];
            if (n <= IMEM_WORDS) begin
                for (int j = 0; j < 4 * n; j++) begin
                    b = 8'($urandom_range(0, 255));
                    frm.push_back(b);
                    x = x ^ b;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) x = x ^ 8'h40;
                frm.push_back(x);
`endif
            end
            run_model();
            do_reload();
            wr_cnt = 0;
            send_frame();
            finish_frame($sformatf("rand%0d", f), m_done, m_err);
        end

        // Asynchronous reset in the middle of a word
        do_reload();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("midword_busy", busy, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_async_core_reset", core_reset, 1'b1);
        check("post_async_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
